// File: rtl/morph_pkg.sv
// morph_pkg: shared defaults, mode/state encodings and padding helper for the morphology stage
package morph_pkg;

    localparam int WIDTH_DEF  = 256;
    localparam int HEIGHT_DEF = 256;
    localparam int ADDR_W_DEF = 16;

    localparam logic MODE_ERODE  = 1'b0;
    localparam logic MODE_DILATE = 1'b1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Neutral element of the window operation: 1 for AND (erosion), 0 for OR (dilation)
    function automatic logic pad_val(input logic mode);
        return mode == MODE_ERODE;
    endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// morph_line_buffer: DEPTH-deep 1-bit shift register delaying the pixel stream by one image row
module morph_line_buffer #(
    parameter int DEPTH = 256
) (
    input  logic morph_clk,
    input  logic morph_rst,
    input  logic shift_en,
    input  logic data,
    output logic tap
);

    logic [DEPTH-1:0] sr;

    // Shift one bit in per enabled cycle; the oldest bit falls out at the top
    always_ff @(posedge morph_clk) begin
        if (morph_rst)
            sr <= '0;
        else if (shift_en)
            sr <= {sr[DEPTH-2:0], data};
    end

    assign tap = sr[DEPTH-1];

endmodule

// File: rtl/morph_filter.sv
// morph_filter: raster-scan 3x3 binary erosion/dilation with border padding and registered output
module morph_filter
    import morph_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              morph_clk,
    input  logic              morph_rst,
    input  logic              morph_start,
    input  logic              morph_mode,
    output logic [ADDR_W-1:0] pixel_address,
    input  logic              bin_data,
    output logic              out_valid,
    output logic              out_data,
    output logic [ADDR_W-1:0] out_address,
    output logic              busy,
    output logic              done,
    output logic [1:0]        condition_led
);

    localparam int N   = WIDTH * HEIGHT;
    localparam int LAT = WIDTH + 1;
    localparam int SW  = ADDR_W + 1;

    localparam logic [SW-1:0]     S_N    = SW'(N);
    localparam logic [SW-1:0]     S_LAT  = SW'(LAT);
    localparam logic [SW-1:0]     S_END  = SW'(N + LAT - 1);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] A_LAT  = ADDR_W'(LAT);
    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(HEIGHT - 1);

    logic [1:0]        state;
    logic [SW-1:0]     s;
    logic              mode;
    logic              sticky;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
    logic [1:0]        w_top, w_mid, w_bot;
    logic              run, pad, in_bit, emit, result;
    logic              tap_mid, tap_top;
    logic [2:0]        t, m, b;

    assign run    = state == RUN;
    assign pad    = pad_val(mode);
    assign in_bit = s < S_N ? bin_data : pad;
    assign emit   = run && s >= S_LAT;

    assign pixel_address = s < S_N ? s[ADDR_W-1:0] : A_LAST;
    assign busy          = run;
    assign condition_led = {sticky, busy};

    morph_line_buffer #(.DEPTH(WIDTH)) u_lb0 (
        .morph_clk (morph_clk),
        .morph_rst (morph_rst),
        .shift_en  (run),
        .data      (in_bit),
        .tap       (tap_mid)
    );

    morph_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
        .morph_clk (morph_clk),
        .morph_rst (morph_rst),
        .shift_en  (run),
        .data      (tap_mid),
        .tap       (tap_top)
    );

    // Window rows are {left, centre, right}; border columns/rows are replaced by the neutral value
    assign t = row == '0     ? {3{pad}} : {col == '0 ? pad : w_top[1], w_top[0], col == C_LAST ? pad : tap_top};
    assign m = {col == '0 ? pad : w_mid[1], w_mid[0], col == C_LAST ? pad : tap_mid};
    assign b = row == R_LAST ? {3{pad}} : {col == '0 ? pad : w_bot[1], w_bot[0], col == C_LAST ? pad : in_bit};

    assign result = mode == MODE_DILATE ? |{t, m, b} : &{t, m, b};

    // Shift the three column taps into the two stored window columns
    always_ff @(posedge morph_clk) begin
        if (morph_rst) begin
            w_top <= '0;
            w_mid <= '0;
            w_bot <= '0;
        end else if (run) begin
            w_top <= {w_top[0], tap_top};
            w_mid <= {w_mid[0], tap_mid};
            w_bot <= {w_bot[0], in_bit};
        end
    end

    // Scan FSM, output-position counters, registered results and status flags
    always_ff @(posedge morph_clk) begin
        if (morph_rst) begin
            state       <= IDLE;
            s           <= '0;
            mode        <= MODE_ERODE;
            sticky      <= 1'b0;
            col         <= '0;
            row         <= '0;
            out_valid   <= 1'b0;
            out_data    <= 1'b0;
            out_address <= '0;
            done        <= 1'b0;
        end else begin
            done        <= state == DONE;
            sticky      <= sticky | (state == DONE);
            out_valid   <= emit;
            out_data    <= emit && result;
            out_address <= emit ? s[ADDR_W-1:0] - A_LAT : '0;
            if (state == IDLE && morph_start && !done) begin
                state  <= RUN;
                s      <= '0;
                mode   <= morph_mode;
                sticky <= 1'b0;
                col    <= '0;
                row    <= '0;
            end else if (run) begin
                s     <= s == S_END ? '0 : s + 1'b1;
                state <= s == S_END ? DONE : RUN;
                if (emit) begin
                    col <= col == C_LAST ? '0 : col + 1'b1;
                    row <= col == C_LAST ? row + 1'b1 : row;
                end
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_morph_filter.sv
// tb_morph_filter: directed frames on a small 8x6 image with hand-computed expected outputs
module tb_morph_filter;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int AW  = 8;
    localparam int N   = W * H;
    localparam int LAT = W + 1;

    logic          morph_clk = 1'b0;
    logic          morph_rst = 1'b1;
    logic          morph_start = 1'b0;
    logic          morph_mode = 1'b0;
    logic          bin_data;
    logic [AW-1:0] pixel_address;
    logic          out_valid;
    logic          out_data;
    logic [AW-1:0] out_address;
    logic          busy;
    logic          done;
    logic [1:0]    condition_led;

    logic img [N];
    logic got [N];
    logic want [N];

    int total = 0;
    int bad = 0;

    morph_filter #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .morph_clk     (morph_clk),
        .morph_rst     (morph_rst),
        .morph_start   (morph_start),
        .morph_mode    (morph_mode),
        .pixel_address (pixel_address),
        .bin_data      (bin_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_address   (out_address),
        .busy          (busy),
        .done          (done),
        .condition_led (condition_led)
    );

    assign bin_data = img[int'(pixel_address)];

    always #5 morph_clk = ~morph_clk;

    // Single checking point for every comparison
    task automatic chk(input string tag, input logic [31:0] seen, input logic [31:0] need);
        total++;
        if (seen !== need) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, seen, need);
        end
    endtask

    task automatic fill_img(input logic v);
        for (int i = 0; i < N; i++) img[i] = v;
    endtask

    task automatic fill_want(input logic v);
        for (int i = 0; i < N; i++) want[i] = v;
    endtask

    task automatic check_pixels(input string tag);
        for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(want[i]));
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_oaddr"}, 32'(out_address), 0);
        chk({tag, "_paddr"}, 32'(pixel_address), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_led"}, 32'(condition_led), 0);
    endtask

    // Run one frame; optionally pulse start with the opposite mode mid-run
    task automatic run_frame(input logic mode_in, input bit poke);
        int first_k = -1;
        int done_k = -1;
        int nvalid = 0;
        for (int i = 0; i < N; i++) got[i] = 1'bx;
        @(negedge morph_clk);
        morph_start = 1'b1;
        morph_mode = mode_in;
        @(negedge morph_clk);
        morph_start = 1'b0;
        chk("busy_at_start", 32'(busy), 1);
        chk("led_at_start", 32'(condition_led), 32'b01);
        for (int k = 1; k <= N + LAT + 10; k++) begin
            @(negedge morph_clk);
            if (out_valid) begin
                if (first_k < 0) first_k = k;
                chk("addr_seq", 32'(out_address), 32'(nvalid));
                if (int'(out_address) < N) got[int'(out_address)] = out_data;
                nvalid++;
            end
            if (done) begin
                done_k = k;
                break;
            end
            morph_start = poke && k == 20;
            morph_mode = (poke && k == 20) ? ~mode_in : mode_in;
        end
        chk("first_valid_cycle", 32'(first_k), 32'(LAT + 1));
        chk("valid_count", 32'(nvalid), 32'(N));
        chk("done_cycle", 32'(done_k), 32'(LAT + N + 1));
        chk("led_after_done", 32'(condition_led), 32'b10);
        morph_start = 1'b1;
        @(negedge morph_clk);
        morph_start = 1'b0;
        chk("start_at_done_ignored", 32'(busy), 0);
        chk("done_single_cycle", 32'(done), 0);
    endtask

    initial begin
        repeat (2) @(negedge morph_clk);
        check_idle_zero("reset");
        morph_rst = 1'b0;

        // All ones, erosion: padding keeps borders at 1
        fill_img(1'b1);
        fill_want(1'b1);
        run_frame(1'b0, 1'b0);
        check_pixels("ones_erode");

        // Single centre pixel (row 3, col 4), dilation, with a start pulse mid-run
        fill_img(1'b0);
        img[28] = 1'b1;
        fill_want(1'b0);
        foreach (want[i]) if (i inside {19, 20, 21, 27, 28, 29, 35, 36, 37}) want[i] = 1'b1;
        run_frame(1'b1, 1'b1);
        check_pixels("centre_dilate");

        // Pixel at row 0, last column: no wrap into the next row
        fill_img(1'b0);
        img[7] = 1'b1;
        fill_want(1'b0);
        want[6] = 1'b1; want[7] = 1'b1; want[14] = 1'b1; want[15] = 1'b1;
        run_frame(1'b1, 1'b0);
        check_pixels("edge_dilate");

        // Checkerboard: erosion all 0, dilation all 1
        for (int i = 0; i < N; i++) img[i] = logic'(((i / W) + (i % W)) % 2);
        fill_want(1'b0);
        run_frame(1'b0, 1'b0);
        check_pixels("checker_erode");
        fill_want(1'b1);
        run_frame(1'b1, 1'b0);
        check_pixels("checker_dilate");

        // Single hole at row 0, last column, erosion
        fill_img(1'b1);
        img[7] = 1'b0;
        fill_want(1'b1);
        want[6] = 1'b0; want[7] = 1'b0; want[14] = 1'b0; want[15] = 1'b0;
        run_frame(1'b0, 1'b0);
        check_pixels("edge_erode");

        // Reset mid-scan abandons the frame without done
        @(negedge morph_clk);
        morph_start = 1'b1;
        morph_mode = 1'b1;
        @(negedge morph_clk);
        morph_start = 1'b0;
        repeat (30) @(negedge morph_clk);
        morph_rst = 1'b1;
        @(negedge morph_clk);
        check_idle_zero("midrst");
        morph_rst = 1'b0;
        @(negedge morph_clk);
        chk("midrst_no_done", 32'(done), 0);

        // Fresh frame after reset: bottom-left corner pixel, dilation
        fill_img(1'b0);
        img[40] = 1'b1;
        fill_want(1'b0);
        want[32] = 1'b1; want[33] = 1'b1; want[40] = 1'b1; want[41] = 1'b1;
        run_frame(1'b1, 1'b0);
        check_pixels("after_rst_dilate");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morph_filter.md
Name: morph_filter

Overview:
- 3x3 binary morphology stage (erosion or dilation) placed directly downstream of the binarization stage.
- Drives `pixel_address` to read the 1-bit `bin_data` map in raster order, one pixel per clock.
- Builds the 3x3 window using two line buffers plus window shift registers.
- Emits the filtered pixel stream with an address and a valid flag for the display/store stage that follows.

Parameters:
- WIDTH, 256, image width in pixels
- HEIGHT, 256, image height in pixels
- ADDR_W, 16, address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
- morph_clk  in  1  single clock for the block
- morph_rst  in  1  synchronous, active-high reset
- morph_start  in  1  one-cycle start request; sampled only in IDLE
- morph_mode  in  1  0 = erosion (AND of window), 1 = dilation (OR of window); latched at start
- pixel_address  out  ADDR_W  read address into the binarization map
- bin_data  in  1  binarized pixel at `pixel_address`; combinational read, valid in the same cycle
- out_valid  out  1  high when `out_data`/`out_address` hold a result
- out_data  out  1  filtered pixel
- out_address  out  ADDR_W  raster index of `out_data`
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last output
- condition_led  out  2  [0] = busy, [1] = sticky done; cleared at the next start or by reset

Behaviour:
- Reset values, applied on the next morph_clk edge with morph_rst high:
  - all outputs 0, state = IDLE, scan counter 0
  - line buffers and window cleared, latched mode 0
  - reset overrides everything, including mid-scan; a partial frame is abandoned and `done` is not pulsed.
- Arithmetic: N = WIDTH*HEIGHT, LAT = WIDTH+1.
- States:
  - IDLE: `morph_start` -> RUN; scan counter s = 0; latch `morph_mode`; clear sticky done.
  - RUN:
    - s increments by 1 each cycle.
    - When s = N+LAT-1, next state is DONE.
    - `morph_start` is ignored.
  - DONE: `done` = 1 for exactly one cycle, then IDLE.
- Read side:
  - `pixel_address` = s while s < N.
  - For s >= N, `pixel_address` holds N-1 and the input bit is forced to the padding value.
- Padding value (neutral element): 1 for erosion, 0 for dilation. The same value applies to all out-of-image neighbours: row -1, row HEIGHT, column -1 and column WIDTH.
- Window update:
  - Each RUN cycle the input bit enters line buffer 0.
  - The oldest bit of line buffer 0 enters line buffer 1.
  - Line buffers are WIDTH-deep 1-bit shift registers.
  - The three column taps (input, LB0 out, LB1 out) shift into the 3x3 window.
- Output:
  - Output index o = s-LAT, valid for LAT <= s <= N+LAT-1.
  - Result is registered: `out_valid`/`out_data`/`out_address` appear on the edge after the cycle with scan value s.
  - `out_valid` is high for exactly N consecutive cycles; `out_address` runs 0..N-1 with no gaps.
- Column masking:
  - At output column 0, the left window column is replaced by padding.
  - At column WIDTH-1, the right window column is replaced by padding.
  - This prevents wrap-around between adjacent rows.
- Row masking: for output row 0 the top row is padding; for output row HEIGHT-1 the bottom row is padding.
- Total run length: N+LAT cycles in RUN (65793 at defaults), plus 1 cycle in DONE.
- A start asserted in the same cycle as `done` is ignored; a new start is accepted from IDLE on the following cycle.

Decomposition:
- Package `morph_pkg`:
  - WIDTH/HEIGHT/ADDR_W defaults
  - mode encodings MODE_ERODE = 0, MODE_DILATE = 1
  - state enum IDLE/RUN/DONE
  - function `pad_val(mode)`
- Sub-module `morph_line_buffer`: parameterised DEPTH, 1-bit shift register with shift enable, synchronous clear on `morph_rst`. Instantiate it twice.

Test Plan:
- All-ones map, erosion -> out_valid high for 65536 cycles; every out_data = 1, because padding 1 is neutral at the borders.
- Single 1 at index 32896 (row 128, col 128), dilation -> out_data = 1 at exactly the 9 addresses 128±1 rows × 128±1 cols, 0 elsewhere.
- Single 1 at index 255 (row 0, col 255), dilation -> 1s at 254, 255, 510, 511 only; nothing at 256 (no row wrap).
- Checkerboard, erosion -> all outputs 0; same map, dilation -> all outputs 1.
- Timing:
  - first out_valid occurs 258 cycles after start is sampled, with out_address 0;
  - done pulses one cycle after the last valid;
  - start asserted during RUN has no effect.
- morph_rst asserted at s = 30000 -> next cycle: all outputs 0, state IDLE, no done; a new start then produces a complete, correct frame.
